// File: rtl/des_f_func.sv
// des_f_func -- one DES round function f(R,K) driving external S-box ROMs.
//
// The expansion E, the key XOR and the S-box address split are pure
// wiring. The row/column addresses are registered when a request is
// accepted. The S-box ROM outputs are captured ROM_LATENCY+1 edges later,
// then permuted by P and held until the consumer takes the result.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   in_valid      r_in/subkey valid
//   in_ready      block idle and able to accept
//   r_in[31:0]    right half R (DES bit 1 = MSB)
//   subkey[47:0]  round key K (DES bit 1 = MSB)
//   sb_row[15:0]  S-box row addresses, S1 in [15:14] .. S8 in [1:0]
//   sb_col[31:0]  S-box column addresses, S1 in [31:28] .. S8 in [3:0]
//   sb_dout[31:0] S-box ROM outputs, S1 in [31:28] .. S8 in [3:0]
//   out_valid     f_out valid, held until out_ready
//   out_ready     consumer accepts f_out
//   f_out[31:0]   f(R,K) (DES bit 1 = MSB)

// Address split for one S-box: 6-bit group b1..b6 (b1 = MSB).
module des_f_sbox_addr (
  input  logic [5:0] grp,
  output logic [1:0] row,
  output logic [3:0] col
);
  assign row = {grp[5], grp[0]};
  assign col = grp[4:1];
endmodule

module des_f_func #(
  parameter int ROM_LATENCY = 1   // edges from address register to valid sb_dout, 1..4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] r_in,
  input  logic [47:0] subkey,
  output logic [15:0] sb_row,
  output logic [31:0] sb_col,
  input  logic [31:0] sb_dout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] f_out
);
  localparam int NUM_LANES = 8;
  // The counter has to reach ROM_LATENCY, so a latency of 4 needs a third bit.
  localparam int CNT_W = (ROM_LATENCY > 3) ? 3 : 2;

  // DES tables, 1-based bit numbers with bit 1 = MSB.
  localparam int E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  typedef enum logic [1:0] {IDLE, LOOKUP, HOLD} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       sb_row_q, sb_row_d;
  logic [31:0]       sb_col_q, sb_col_d;
  logic [31:0]       f_out_q, f_out_d;
  logic              out_valid_q, out_valid_d;

  logic [47:0]       e_r, x;
  logic [31:0]       p_out;
  // Lane g serves S-box 8-g, so the packed arrays line up with sb_row/sb_col.
  logic [NUM_LANES-1:0][5:0] grp;
  logic [NUM_LANES-1:0][1:0] row_l;
  logic [NUM_LANES-1:0][3:0] col_l;

  for (genvar j = 0; j < 48; j++) begin : g_e
    assign e_r[47-j] = r_in[32-E_TAB[j]];
  end

  assign x = e_r ^ subkey;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign grp[g] = x[6*g +: 6];
    des_f_sbox_addr u_addr (
      .grp (grp[g]),
      .row (row_l[g]),
      .col (col_l[g])
    );
  end

  for (genvar j = 0; j < 32; j++) begin : g_p
    assign p_out[31-j] = sb_dout[32-P_TAB[j]];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sb_row_d    = sb_row_q;
    sb_col_d    = sb_col_q;
    f_out_d     = f_out_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sb_row_d = row_l;
          sb_col_d = col_l;
          cnt_d    = '0;
          state_d  = LOOKUP;
        end
      end
      LOOKUP: begin
        // cnt equals ROM_LATENCY on the edge after sb_dout became valid
        if (cnt_q == CNT_W'(ROM_LATENCY)) begin
          f_out_d     = p_out;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sb_row_q    <= '0;
      sb_col_q    <= '0;
      f_out_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sb_row_q    <= sb_row_d;
      sb_col_q    <= sb_col_d;
      f_out_q     <= f_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign sb_row    = sb_row_q;
  assign sb_col    = sb_col_q;
  assign f_out     = f_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_des_f_func.sv
// Bench for des_f_func: u1 (ROM_LATENCY=1) gets a one-stage ROM that knows
// the textbook round-1 S-box output, u2 (ROM_LATENCY=2) gets a two-stage
// stub ROM returning {row, col[15:0]}.
module tb_des_f_func;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic        rst1 = 1'b1, iv1 = 1'b0, ore1 = 1'b1, ir1, ov1;
  logic [31:0] r1 = '0, f1, col1;
  logic [47:0] k1 = '0;
  logic [15:0] row1;
  logic [31:0] dout1 = '0;

  logic        rst2 = 1'b1, iv2 = 1'b0, ore2 = 1'b1, ir2, ov2;
  logic [31:0] r2 = '0, f2, col2;
  logic [47:0] k2 = '0;
  logic [15:0] row2;
  logic [31:0] p2a = '0, dout2 = '0;

  des_f_func #(.ROM_LATENCY(1)) u1 (
    .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(ir1), .r_in(r1),
    .subkey(k1), .sb_row(row1), .sb_col(col1), .sb_dout(dout1),
    .out_valid(ov1), .out_ready(ore1), .f_out(f1));

  des_f_func #(.ROM_LATENCY(2)) u2 (
    .clk(clk), .rst(rst2), .in_valid(iv2), .in_ready(ir2), .r_in(r2),
    .subkey(k2), .sb_row(row2), .sb_col(col2), .sb_dout(dout2),
    .out_valid(ov2), .out_ready(ore2), .f_out(f2));

  function automatic logic [31:0] rom1_fn(input logic [15:0] row, input logic [31:0] col);
    if (row == 16'h12E3 && col == 32'hC8FD03A3) return 32'h5C82B597;
    return {row, col[15:0]};
  endfunction

  always @(posedge clk) dout1 <= rom1_fn(row1, col1);
  always @(posedge clk) begin
    p2a   <= {row2, col2[15:0]};
    dout2 <= p2a;
  end

  task automatic test_reset;
    rst1 = 1'b1; rst2 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (ir1 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", ir1); end
    total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", ov1); end
    total++; if (f1 !== 32'h0) begin bad++; $display("FAIL reset_f_out got=%h exp=0", f1); end
    total++; if (row1 !== 16'h0 || col1 !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h/%h exp=0/0", row1, col1); end
    total++; if (ir2 !== 1'b1 || ov2 !== 1'b0) begin bad++; $display("FAIL reset_u2 got ir=%b ov=%b exp 1/0", ir2, ov2); end
    rst1 = 1'b0; rst2 = 1'b0;
  endtask

  task automatic test_addr;
    @(negedge clk); r1 = '0; k1 = '0; iv1 = 1'b1;
    @(negedge clk); iv1 = 1'b0;
    total++; if (row1 !== 16'h0000 || col1 !== 32'h0) begin bad++; $display("FAIL addr_zero got=%h/%h exp=0000/00000000", row1, col1); end
    repeat (4) @(negedge clk);
    r1 = '0; k1 = 48'hFFFF_FFFF_FFFF; iv1 = 1'b1;
    @(negedge clk); iv1 = 1'b0;
    total++; if (row1 !== 16'hFFFF || col1 !== 32'hFFFFFFFF) begin bad++; $display("FAIL addr_ones got=%h/%h exp=FFFF/FFFFFFFF", row1, col1); end
    total++; if (ir1 !== 1'b0) begin bad++; $display("FAIL addr_busy got=%b exp=0", ir1); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_known;
    int n;
    r1 = 32'hF0AAF0AA; k1 = 48'h1B02EFFC7072; iv1 = 1'b1;
    @(negedge clk); iv1 = 1'b0;
    total++; if (row1 !== 16'h12E3 || col1 !== 32'hC8FD03A3) begin bad++; $display("FAIL known_addr got=%h/%h exp=12E3/C8FD03A3", row1, col1); end
    n = 0;
    while (ov1 !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    total++; if (n != 2) begin bad++; $display("FAIL known_latency got=%0d exp=2", n); end
    total++; if (f1 !== 32'h234AA9BB) begin bad++; $display("FAIL known_f_out got=%h exp=234AA9BB", f1); end
    @(negedge clk);
    total++; if (ov1 !== 1'b0 || ir1 !== 1'b1) begin bad++; $display("FAIL known_release got ov=%b ir=%b exp 0/1", ov1, ir1); end
  endtask

  task automatic test_backpressure;
    int n;
    ore1 = 1'b0; r1 = '0; k1 = 48'hFFFF_FFFF_FFFF; iv1 = 1'b1;
    @(negedge clk); iv1 = 1'b0;
    n = 0;
    while (ov1 !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    total++; if (ov1 !== 1'b1 || f1 !== 32'hFFFFFFFF) begin bad++; $display("FAIL bp_result got ov=%b f=%h exp 1/FFFFFFFF", ov1, f1); end
    for (int i = 0; i < 5; i++) begin
      iv1 = 1'b1; r1 = 32'hF0AAF0AA; k1 = 48'h1B02EFFC7072;
      @(negedge clk);
      total++; if (ov1 !== 1'b1 || f1 !== 32'hFFFFFFFF) begin bad++; $display("FAIL bp_hold[%0d] got ov=%b f=%h exp 1/FFFFFFFF", i, ov1, f1); end
      total++; if (ir1 !== 1'b0 || row1 !== 16'hFFFF) begin bad++; $display("FAIL bp_ignore[%0d] got ir=%b row=%h exp 0/FFFF", i, ir1, row1); end
    end
    iv1 = 1'b0; ore1 = 1'b1;
    @(negedge clk);
    total++; if (ov1 !== 1'b0 || ir1 !== 1'b1) begin bad++; $display("FAIL bp_release got ov=%b ir=%b exp 0/1", ov1, ir1); end
  endtask

  task automatic test_reset_mid;
    int seen;
    r1 = 32'hF0AAF0AA; k1 = 48'h1B02EFFC7072; iv1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b1;   // in LOOKUP now; in_valid stays high alongside rst
    @(negedge clk);
    total++; if (ov1 !== 1'b0 || f1 !== 32'h0) begin bad++; $display("FAIL rstmid_out got ov=%b f=%h exp 0/0", ov1, f1); end
    total++; if (row1 !== 16'h0 || col1 !== 32'h0) begin bad++; $display("FAIL rstmid_addr got=%h/%h exp=0/0", row1, col1); end
    total++; if (ir1 !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%b exp=1", ir1); end
    rst1 = 1'b0; iv1 = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ov1 === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rstmid_stale got=%0d exp=0", seen); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vr [3];
    logic [47:0] vk [3];
    logic [31:0] ve [3];
    int k, n, last, c0;
    vr[0] = 32'hF0AAF0AA; vk[0] = 48'h1B02EFFC7072; ve[0] = 32'hC0632D07;
    vr[1] = 32'h0;        vk[1] = 48'h0;            ve[1] = 32'h0;
    vr[2] = 32'h0;        vk[2] = 48'hFFFF_FFFF_FFFF; ve[2] = 32'hFFFFFFFF;
    @(negedge clk);
    r2 = vr[0]; k2 = vk[0]; iv2 = 1'b1; ore2 = 1'b1;
    c0 = cyc; k = 0; n = 0; last = 0;
    while (k < 3 && n < 80) begin
      @(negedge clk); n++;
      if (ov2 === 1'b1) begin
        total++; if (f2 !== ve[k]) begin bad++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k, f2, ve[k]); end
        if (k == 0) begin
          total++; if (cyc - c0 != 4) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=4", cyc - c0); end
        end else begin
          total++; if (cyc - last != 5) begin bad++; $display("FAIL b2b_period[%0d] got=%0d exp=5", k, cyc - last); end
        end
        last = cyc; k++;
        if (k < 3) begin r2 = vr[k]; k2 = vk[k]; end
      end
    end
    iv2 = 1'b0;
    total++; if (k != 3) begin bad++; $display("FAIL b2b_timeout got=%0d results exp=3", k); end
  endtask

  initial begin
    test_reset;
    test_addr;
    test_known;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/des_f_func.md
DES_F_FUNC -- requirements
Module: des_f_func

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter: ROM_LATENCY, 1, clock cycles from a registered row/col change to valid S-box dout (range 1..4).
REQ-003 Ports, in order:
  clk  in  1  rising-edge clock
  rst  in  1  synchronous active-high reset
  in_valid  in  1  r_in/subkey valid
  in_ready  out  1  block can accept
  r_in  in  32  right half R, DES bit 1 = MSB
  subkey  in  48  round key K, DES bit 1 = MSB
  sb_row  out  16  S-box row addresses, S1 in [15:14] ... S8 in [1:0]
  sb_col  out  32  S-box column addresses, S1 in [31:28] ... S8 in [3:0]
  sb_dout  in  32  S-box ROM outputs, S1 in [31:28] ... S8 in [3:0]
  out_valid  out  1  f_out valid
  out_ready  in  1  consumer accepts f_out
  f_out  out  32  f(R,K), DES bit 1 = MSB

Function
REQ-004 SHALL compute X = E(r_in) XOR subkey, with E output bits (DES numbering) = 32 1 2 3 4 5 4 5 6 7 8 9 8 9 10 11 12 13 12 13 14 15 16 17 16 17 18 19 20 21 20 21 22 23 24 25 24 25 26 27 28 29 28 29 30 31 32 1.
REQ-005 SHALL split X into eight 6-bit groups b1..b6, group 1 = X bits 1..6; row = {b1,b6}, col = {b2,b3,b4,b5}.
REQ-006 SHALL apply P to captured sb_dout: f_out bits = 16 7 20 21 29 12 28 17 1 15 23 26 5 18 31 10 2 8 24 14 32 27 3 9 19 13 30 6 22 11 4 25.
REQ-007 FSM states IDLE, LOOKUP, HOLD; 2-bit wait counter cnt.
REQ-008 IDLE: in_ready=1; on in_valid at edge T0: register sb_row/sb_col from REQ-005, cnt<=0, go LOOKUP.
REQ-009 LOOKUP: in_ready=0; cnt increments each edge; at edge where cnt==ROM_LATENCY: f_out<=P(sb_dout), out_valid<=1, go HOLD.
REQ-010 Latency: out_valid rises at edge T0+1+ROM_LATENCY (ROM_LATENCY=1: 2 cycles after accept).
REQ-011 sb_row/sb_col SHALL be registered and stable from T0 until the next accept; r_in/subkey sampled only at accept.
REQ-012 HOLD: in_ready=0; f_out and out_valid held stable while out_ready=0.
REQ-013 HOLD with out_ready=1: out_valid<=0, go IDLE; in_ready=1 in the next cycle (no same-cycle pass-through). Max throughput: one result per ROM_LATENCY+3 cycles.
REQ-014 in_valid while not IDLE SHALL be ignored, with no state or register change.
REQ-015 out_ready while not HOLD SHALL be ignored.

Reset
REQ-016 rst=1 at an edge SHALL force IDLE, cnt=0, sb_row=0, sb_col=0, f_out=0, out_valid=0, in_ready=1 from the next cycle, in any state.
REQ-017 rst SHALL override simultaneous in_valid/out_ready; an in-flight lookup is discarded and no out_valid is produced for it.

Verification
REQ-018 Known vector with eight real S-box ROMs, ROM_LATENCY=1: r_in=F0AAF0AA, subkey=1B02EFFC7072 -> sb_dout=5C82B597, f_out=234AA9BB, out_valid 2 cycles after accept.
REQ-019 Address check: r_in=0, subkey=0 -> sb_row=0000, sb_col=00000000; r_in=0, subkey=FFFFFFFFFFFF -> sb_row=FFFF, sb_col=FFFFFFFF.
REQ-020 Backpressure: hold out_ready=0 for 5 cycles in HOLD -> f_out and out_valid unchanged; in_valid pulses ignored; one out_ready pulse -> in_ready=1 the following cycle.
REQ-021 Reset mid-op: assert rst in LOOKUP -> next cycle all outputs 0, in_ready=1; no stale out_valid afterwards.
REQ-022 ROM_LATENCY=2 with a stub ROM (dout = {row,col} low bits, delayed 2 cycles) and in_valid held high -> accepts every 5 cycles; each f_out = P of its own lookup; no result mixes data from adjacent operations.
